// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue producer-side handshake bundle.
// Producer drives data/valid, the queue drives ready.
interface uart_tx_queue_if #(
  parameter int DATA_WIDTH = 9
);

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: FIFO-buffered transmit front-end for the uart.
// Issues one word per tx strobe, paced on tx_busy, with arm timeout.
module uart_tx_queue #(
  parameter int DATA_WIDTH  = 9,
  parameter int DEPTH_LOG2  = 4,
  parameter int ARM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_tx_queue_if.slave        in_if,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx,
  input  logic                  tx_busy,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  drop
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(ARM_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   LVL_MAX = (DEPTH_LOG2 + 1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_ARMED = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level_nxt;
  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic                  push;
  logic                  pop;

  assign in_if.in_ready = !full;

  // Flush discards a same-cycle push; a pop still goes out.
  assign push = in_if.in_valid && !full && !flush;
  assign pop  = (state == S_IDLE) && !empty && !tx_busy;

  // Next occupancy from the push/pop pair.
  always_comb begin
    level_nxt = level;
    unique case ({push, pop})
      2'b10:   level_nxt = level + LVL_ONE;
      2'b01:   level_nxt = level - LVL_ONE;
      default: level_nxt = level;
    endcase
  end

  // Storage array; pointer gating makes stray writes harmless.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_if.in_data;
    end
  end

  // Pointers and registered occupancy flags.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      level <= level_nxt;
      empty <= (level_nxt == '0);
      full  <= (level_nxt == LVL_MAX);
    end
  end

  // Issue FSM: strobe, wait for busy to rise, then to fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      tx      <= 1'b0;
      tx_data <= '0;
      drop    <= 1'b0;
      cnt     <= '0;
    end else begin
      drop <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            state   <= S_ISSUE;
            tx      <= 1'b1;
            tx_data <= mem[rd_ptr];
          end
        end
        S_ISSUE: begin
          state <= S_ARMED;
          tx    <= 1'b0;
          cnt   <= '0;
        end
        S_ARMED: begin
          if (tx_busy) begin
            state <= S_DRAIN;
          end else if (cnt == CNT_LAST) begin
            state <= S_IDLE;
            drop  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_DRAIN: begin
          if (!tx_busy) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed bench with a simple uart busy model.
// Expected values are hand-derived constants.
module tb_uart_tx_queue;

  localparam int DW = 9;
  localparam int DL = 4;
  localparam int AT = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          tx_busy = 1'b0;
  logic [DW-1:0] tx_data;
  logic          tx;
  logic [DL:0]   level;
  logic          empty;
  logic          full;
  logic          drop;

  uart_tx_queue_if #(.DATA_WIDTH(DW)) qif ();

  uart_tx_queue #(
    .DATA_WIDTH  (DW),
    .DEPTH_LOG2  (DL),
    .ARM_TIMEOUT (AT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_if   (qif),
    .flush   (flush),
    .tx_data (tx_data),
    .tx      (tx),
    .tx_busy (tx_busy),
    .level   (level),
    .empty   (empty),
    .full    (full),
    .drop    (drop)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int strobes = 0;
  int drops = 0;
  int rise_cnt = 0;
  int hold = 0;
  int busy_len = 100;
  int err;
  int w;
  bit model_en = 1'b1;
  bit force_busy = 1'b0;
  bit mbusy = 1'b0;
  bit rdy;
  logic [DW-1:0] got[$];
  int tx_cyc[$];
  int drop_cyc[$];

  task automatic chk(input string tag, input logic [31:0] got_v,
                     input logic [31:0] exp_v);
    n_chk++;
    if (got_v === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
  endtask

  // One clock: observe outputs after the edge, then advance uart model.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (tx === 1'b1) begin
      strobes++;
      got.push_back(tx_data);
      tx_cyc.push_back(cyc);
      if (model_en) rise_cnt = 2;
    end
    if (drop === 1'b1) begin
      drops++;
      drop_cyc.push_back(cyc);
    end
    if (rise_cnt > 0) begin
      rise_cnt--;
      if (rise_cnt == 0) begin
        mbusy = 1'b1;
        hold = busy_len;
      end
    end else if (mbusy) begin
      hold--;
      if (hold <= 0) mbusy = 1'b0;
    end
    tx_busy = force_busy | mbusy;
  endtask

  task automatic set_force(input bit v);
    force_busy = v;
    tx_busy = force_busy | mbusy;
  endtask

  task automatic clear_log();
    got.delete();
    tx_cyc.delete();
    drop_cyc.delete();
    strobes = 0;
    drops = 0;
  endtask

  initial begin
    qif.in_data = '0;
    qif.in_valid = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ready", qif.in_ready, 1);
    chk("rst_tx", tx, 0);
    chk("rst_txdata", tx_data, 0);
    chk("rst_drop", drop, 0);
    rst_n = 1'b1;
    tick();

    // Single word, long busy
    clear_log();
    busy_len = 100;
    qif.in_data = 9'h055;
    qif.in_valid = 1'b1;
    tick();
    qif.in_valid = 1'b0;
    chk("t1_lvl1", level, 1);
    tick();
    chk("t1_tx", tx, 1);
    chk("t1_data", tx_data, 9'h055);
    chk("t1_lvl0", level, 0);
    for (int i = 0; i < 110; i++) tick();
    chk("t1_strobes", strobes, 1);
    chk("t1_hold", tx_data, 9'h055);

    // Burst fill while uart busy, 17th ignored
    clear_log();
    set_force(1'b1);
    qif.in_valid = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      qif.in_data = DW'(i);
      tick();
    end
    qif.in_valid = 1'b0;
    chk("t2_full", full, 1);
    chk("t2_ready", qif.in_ready, 0);
    chk("t2_level", level, 16);
    chk("t2_nostrobe", strobes, 0);
    busy_len = 3;
    set_force(1'b0);
    for (int i = 0; i < 400 && strobes < 16; i++) tick();
    for (int i = 0; i < 20; i++) tick();
    chk("t2_count", strobes, 16);
    for (int i = 0; i < 16 && i < got.size(); i++)
      chk($sformatf("t2_word%0d", i), got[i], i + 1);
    chk("t2_empty", empty, 1);

    // Simultaneous push/pop at level 3, then wrap 40 words
    clear_log();
    busy_len = 2;
    set_force(1'b1);
    qif.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      qif.in_data = DW'(9'h100 + i);
      tick();
    end
    qif.in_valid = 1'b0;
    chk("t3_lvl3", level, 3);
    qif.in_data = 9'h103;
    qif.in_valid = 1'b1;
    set_force(1'b0);
    tick();
    chk("t3_pp_level", level, 3);
    chk("t3_pp_tx", tx, 1);
    chk("t3_pp_data", tx_data, 9'h100);
    w = 9'h104;
    for (int i = 0; i < 2000 && w <= 9'h127; i++) begin
      qif.in_data = DW'(w);
      qif.in_valid = 1'b1;
      rdy = qif.in_ready;
      tick();
      if (rdy) w++;
    end
    qif.in_valid = 1'b0;
    for (int i = 0; i < 1000 && strobes < 40; i++) tick();
    for (int i = 0; i < 10; i++) tick();
    chk("t3_count", strobes, 40);
    err = 0;
    for (int i = 0; i < got.size(); i++)
      if (got[i] !== DW'(9'h100 + i)) err++;
    chk("t3_order_errs", err, 0);

    // Arm timeout: busy never rises
    clear_log();
    model_en = 1'b0;
    set_force(1'b1);
    qif.in_valid = 1'b1;
    qif.in_data = 9'h0AA;
    tick();
    qif.in_data = 9'h0BB;
    tick();
    qif.in_valid = 1'b0;
    set_force(1'b0);
    for (int i = 0; i < 60; i++) tick();
    chk("t4_drops", drops, 2);
    chk("t4_strobes", strobes, 2);
    if (tx_cyc.size() >= 2 && drop_cyc.size() >= 1) begin
      chk("t4_drop_dly", drop_cyc[0] - tx_cyc[0], 17);
      chk("t4_next_dly", tx_cyc[1] - drop_cyc[0], 1);
      chk("t4_word2", got[1], 9'h0BB);
    end

    // Flush while draining with level 5
    clear_log();
    model_en = 1'b1;
    busy_len = 20;
    set_force(1'b1);
    qif.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      qif.in_data = DW'(9'h0C0 + i);
      tick();
    end
    qif.in_valid = 1'b0;
    chk("t5_lvl6", level, 6);
    set_force(1'b0);
    for (int i = 0; i < 10 && strobes == 0; i++) tick();
    for (int i = 0; i < 4; i++) tick();
    chk("t5_lvl5", level, 5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_flush_lvl", level, 0);
    chk("t5_flush_empty", empty, 1);
    for (int i = 0; i < 60; i++) tick();
    chk("t5_strobes", strobes, 1);
    chk("t5_data", tx_data, 9'h0C0);

    // Reset while armed with level 4
    clear_log();
    model_en = 1'b0;
    set_force(1'b1);
    qif.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      qif.in_data = DW'(9'h0D0 + i);
      tick();
    end
    qif.in_valid = 1'b0;
    set_force(1'b0);
    for (int i = 0; i < 10 && strobes == 0; i++) tick();
    chk("t6_lvl4", level, 4);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_tx", tx, 0);
    chk("t6_level", level, 0);
    chk("t6_empty", empty, 1);
    model_en = 1'b1;
    busy_len = 3;
    clear_log();
    qif.in_data = 9'h1A5;
    qif.in_valid = 1'b1;
    tick();
    qif.in_valid = 1'b0;
    tick();
    chk("t6_post_tx", tx, 1);
    chk("t6_post_data", tx_data, 9'h1A5);
    for (int i = 0; i < 10; i++) tick();
    chk("t6_post_cnt", strobes, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
